vga_pixel_gen: RTL

- Downstream consumer of the VGA sync generator, clocked by the same pixel clock.
- Takes pixel_x/pixel_y/video_on/h_sync/v_sync from the sync generator and produces the 8-bit RGB (3-3-2) colour for a bordered screen with a blinking rectangular cursor.
- Delays the syncs so they stay aligned with the colour output.
- Cursor position and colour are updated through a 4-phase req/ack handshake; updates are applied only at a frame boundary, so there is no tearing.

---
 rtl/vga_pixel_gen_if.sv | 26 ++
 rtl/vga_pixel_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_gen_if.sv
// Cursor update channel between a control master and vga_pixel_gen (4-phase req/ack).
// Latency: ack rises the cycle after the update lands on a frame boundary.
// Backpressure: the master holds req and data until ack is seen, then drops req and waits for ack low.
interface vga_pixel_gen_if;
    logic [9:0] cur_x;
    logic [9:0] cur_y;
    logic [7:0] cur_color;
    logic       upd_req;
    logic       upd_ack;

    modport master (
        output cur_x,
        output cur_y,
        output cur_color,
        output upd_req,
        input  upd_ack
    );

    modport slave (
        input  cur_x,
        input  cur_y,
        input  cur_color,
        input  upd_req,
        output upd_ack
    );
endinterface

// File: rtl/vga_pixel_gen.sv
// Bordered-screen pixel colour generator with a blinking cursor, fed by the VGA sync generator.
// Latency: fixed 2 cycles from pixel/sync inputs to rgb and delayed syncs.
// Backpressure: none on the pixel stream; cursor updates stall in PEND until the next frame start.
module vga_pixel_gen #(
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter int         BORDER       = 8,
    parameter int         CUR_W        = 8,
    parameter int         CUR_H        = 16,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [7:0] BORDER_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR     = 8'h02
) (
    input  logic              CLK_pix_rate,
    input  logic              reset,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              video_on_in,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    vga_pixel_gen_if.slave    upd,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic [7:0]        rgb
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, PEND, DONE} upd_state_e;

    // Stage 1: registered copy of the sync generator outputs
    logic [9:0] x1_q, y1_q;
    logic       von1_q, hs1_q, vs1_q;
    // Stage 2: colour and syncs aligned with it
    logic [7:0] rgb_q, rgb_d;
    logic       hs2_q, vs2_q;
    // Frame-edge detect: stage-1 position was not (0,0) last cycle
    logic       prev_nz_q, prev_nz_d;
    logic       frame_tick;
    // Update FSM, pending and shadow cursor, blink state
    upd_state_e state_q, state_d;
    logic [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [7:0] pend_c_q, pend_c_d;
    logic [9:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [7:0] sh_c_q, sh_c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       blink_q, blink_d;
    logic       ack_q, ack_d;
    // Colour evaluation helpers
    logic [10:0] x11, y11, sx11, sy11;
    logic        cur_hit, border_hit;

    // Frame start is the first cycle stage 1 shows (0,0), so a held pixel does not retrigger
    always_comb begin
        prev_nz_d  = (x1_q != 10'd0) || (y1_q != 10'd0);
        frame_tick = (x1_q == 10'd0) && (y1_q == 10'd0) && prev_nz_q;
    end

    // Blink counting and the update FSM; an update on a frame tick overrides the blink wrap
    always_comb begin
        state_d  = state_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        pend_c_d = pend_c_q;
        sh_x_d   = sh_x_q;
        sh_y_d   = sh_y_q;
        sh_c_d   = sh_c_q;
        cnt_d    = cnt_q;
        blink_d  = blink_q;
        if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        case (state_q)
            IDLE: begin
                if (upd.upd_req) begin
                    pend_x_d = upd.cur_x;
                    pend_y_d = upd.cur_y;
                    pend_c_d = upd.cur_color;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (frame_tick) begin
                    sh_x_d  = pend_x_q;
                    sh_y_d  = pend_y_q;
                    sh_c_d  = pend_c_q;
                    cnt_d   = '0;
                    blink_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!upd.upd_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == DONE);
    end

    // Colour uses the post-tick cursor/blink so pixel (0,0) of a new frame already reflects them
    always_comb begin
        x11        = {1'b0, x1_q};
        y11        = {1'b0, y1_q};
        sx11       = {1'b0, sh_x_d};
        sy11       = {1'b0, sh_y_d};
        cur_hit    = (x11 >= sx11) && (x11 < sx11 + 11'(CUR_W)) &&
                     (y11 >= sy11) && (y11 < sy11 + 11'(CUR_H));
        border_hit = (x11 < 11'(BORDER)) || (x11 >= 11'(H_ACTIVE - BORDER)) ||
                     (y11 < 11'(BORDER)) || (y11 >= 11'(V_ACTIVE - BORDER));
        rgb_d      = BG_COLOR;
        if (!von1_q) begin
            rgb_d = 8'h00;
        end else if (cur_hit && blink_d) begin
            rgb_d = sh_c_d;
        end else if (border_hit) begin
            rgb_d = BORDER_COLOR;
        end
    end

    // All state registers; syncs reset high (inactive)
    always_ff @(posedge CLK_pix_rate) begin
        if (reset) begin
            x1_q      <= '0;
            y1_q      <= '0;
            von1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rgb_q     <= 8'h00;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            prev_nz_q <= 1'b0;
            state_q   <= IDLE;
            pend_x_q  <= '0;
            pend_y_q  <= '0;
            pend_c_q  <= 8'h00;
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_c_q    <= 8'hE0;
            cnt_q     <= '0;
            blink_q   <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            x1_q      <= pixel_x;
            y1_q      <= pixel_y;
            von1_q    <= video_on_in;
            hs1_q     <= h_sync_in;
            vs1_q     <= v_sync_in;
            rgb_q     <= rgb_d;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            prev_nz_q <= prev_nz_d;
            state_q   <= state_d;
            pend_x_q  <= pend_x_d;
            pend_y_q  <= pend_y_d;
            pend_c_q  <= pend_c_d;
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            sh_c_q    <= sh_c_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            ack_q     <= ack_d;
        end
    end

    assign rgb         = rgb_q;
    assign h_sync_out  = hs2_q;
    assign v_sync_out  = vs2_q;
    assign upd.upd_ack = ack_q;
endmodule
